// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer for the RiscV_iMem_dMem system top.
// Holds all selected reset channels low for HOLD cycles, then releases them
// one at a time in ascending index order, STAGGER cycles apart.
// A masked soft reset re-sequences only the channels it selects.
// Optional watchdog: define RST_SEQ_WDT_EN to add wdt_kick / wdt_fired and an
// automatic full re-sequence when the watchdog is not serviced in RUN.
module rst_seq_ctrl #(
    parameter int N_CH       = 4,
    parameter int HOLD       = 16,
    parameter int STAGGER    = 8,
    parameter int CNT_W      = 8,
    parameter int WDT_CYCLES = 1024,
    parameter int WDT_W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            soft_rst_req,
    input  logic [N_CH-1:0] ch_mask,
`ifdef RST_SEQ_WDT_EN
    input  logic            wdt_kick,
    output logic            wdt_fired,
`endif
    output logic [N_CH-1:0] rst_out_n,
    output logic            busy,
    output logic            seq_done
);

    // Pointer must also encode "no further channel" as the value N_CH.
    localparam int PTR_W = (N_CH < 2) ? 1 : $clog2(N_CH + 1);
    localparam logic [PTR_W-1:0] PTR_NONE = PTR_W'(N_CH);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   sel_q, sel_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_CH-1:0]   rst_out_q, rst_out_d;
    logic              busy_q, busy_d;
    logic              seq_done_q, seq_done_d;
    logic              take_ext;
    logic              take_soft;
    logic              wdt_hit;
    logic [N_CH-1:0]   rel_onehot;

`ifdef RST_SEQ_WDT_EN
    logic [WDT_W-1:0]  wdt_cnt_q, wdt_cnt_d;
    logic              wdt_fired_q, wdt_fired_d;
`else
    // Watchdog sizing is only meaningful when the watchdog is built in.
    if ((64'd1 << WDT_W) <= 64'(WDT_CYCLES)) begin : g_wdt_cfg_unused
    end
`endif

    // Lowest selected channel index at or above 'from'; PTR_NONE if none.
    function automatic logic [PTR_W-1:0] next_sel(input logic [N_CH-1:0] sel,
                                                   input logic [PTR_W-1:0] from);
        logic [PTR_W-1:0] r;
        r = PTR_NONE;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (sel[i] && (i >= int'(from))) begin
                r = PTR_W'(i);
            end
        end
        return r;
    endfunction

    // One-hot decode of the release pointer (all zero when pointer is PTR_NONE).
    function automatic logic [N_CH-1:0] ptr_onehot(input logic [PTR_W-1:0] p);
        logic [N_CH-1:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (PTR_W'(i) == p) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Next-state logic for the sequencer and (optionally) the watchdog.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        rst_out_d  = rst_out_q;
        take_ext   = 1'b0;
        take_soft  = 1'b0;
        wdt_hit    = 1'b0;
        rel_onehot = ptr_onehot(ptr_q);
`ifdef RST_SEQ_WDT_EN
        wdt_cnt_d   = '0;
        wdt_fired_d = 1'b0;
`endif

        case (state_q)
            ST_ASSERT: begin
                // Selected channels stay low; unselected keep their level.
                rst_out_d = rst_out_q & ~sel_q;
                if (cnt_q == CNT_W'(HOLD - 1)) begin
                    state_d = ST_RELEASE;
                    // Preloading the stagger limit makes the first release
                    // happen on the very next edge.
                    cnt_d   = CNT_W'(STAGGER - 1);
                    ptr_d   = next_sel(sel_q, '0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (ptr_q == PTR_NONE) begin
                    // Last selected channel went high on the previous edge.
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STAGGER - 1)) begin
                    rst_out_d = rst_out_q | rel_onehot;
                    ptr_d     = next_sel(sel_q, ptr_q + PTR_W'(1));
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                take_ext = soft_rst_req && (ch_mask != '0);
`ifdef RST_SEQ_WDT_EN
                wdt_hit     = !wdt_kick && (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));
                wdt_fired_d = wdt_hit;
                if (wdt_kick) begin
                    wdt_cnt_d = '0;
                end else begin
                    wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
                end
`endif
                take_soft = take_ext || wdt_hit;
                if (take_ext) begin
                    sel_d = ch_mask;
                end else if (wdt_hit) begin
                    sel_d = '1;
                end
                if (take_soft) begin
                    rst_out_d = rst_out_q & ~sel_d;
                    state_d   = ST_ASSERT;
                    cnt_d     = '0;
                    ptr_d     = '0;
`ifdef RST_SEQ_WDT_EN
                    wdt_cnt_d = '0;
`endif
                end
            end

            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
                sel_d   = '1;
                ptr_d   = '0;
            end
        endcase

        busy_d     = (state_d != ST_RUN);
        seq_done_d = (state_d == ST_RUN);
    end

    // State and registered outputs; rst_n low restarts a full cold sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            sel_q      <= '1;
            ptr_q      <= '0;
            rst_out_q  <= '0;
            busy_q     <= 1'b1;
            seq_done_q <= 1'b0;
`ifdef RST_SEQ_WDT_EN
            wdt_cnt_q   <= '0;
            wdt_fired_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            rst_out_q  <= rst_out_d;
            busy_q     <= busy_d;
            seq_done_q <= seq_done_d;
`ifdef RST_SEQ_WDT_EN
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_fired_q <= wdt_fired_d;
`endif
        end
    end

    assign rst_out_n = rst_out_q;
    assign busy      = busy_q;
    assign seq_done  = seq_done_q;
`ifdef RST_SEQ_WDT_EN
    assign wdt_fired = wdt_fired_q;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl: directed scenarios plus randomized soft resets,
// checked each cycle against an edge-arithmetic reference model.
module tb_rst_seq_ctrl;

    localparam int TB_WDT = 64;

    logic       clk;
    logic       rst_n;
    logic       soft_rst_req;
    logic [3:0] ch_mask;
    logic       wdt_kick;

    logic [3:0] m_out;
    logic       m_busy, m_done;
    logic [0:0] o_out;
    logic       o_busy, o_done;
    logic [7:0] w_out;
    logic       w_busy, w_done;
    logic       m_wdt_fired, o_wdt_fired, w_wdt_fired;

    int checks   = 0;
    int failures = 0;

    // Reference model state: edge counter, start edge (the "edge -1") and set.
    int          ed = 0;
    int          m_s = 0;
    logic [15:0] m_sel = 16'h000F;
    int          r_s = 0;
    int          last_kick = -100000;
    logic        m_fire = 1'b0;

    rst_seq_ctrl #(.N_CH(4), .HOLD(16), .STAGGER(8), .CNT_W(8),
                   .WDT_CYCLES(TB_WDT), .WDT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .ch_mask(ch_mask),
`ifdef RST_SEQ_WDT_EN
        .wdt_kick(wdt_kick), .wdt_fired(m_wdt_fired),
`endif
        .rst_out_n(m_out), .busy(m_busy), .seq_done(m_done));

    rst_seq_ctrl #(.N_CH(1), .HOLD(1), .STAGGER(1)) u_one (
        .clk(clk), .rst_n(rst_n), .soft_rst_req(1'b0), .ch_mask(1'b0),
`ifdef RST_SEQ_WDT_EN
        .wdt_kick(1'b1), .wdt_fired(o_wdt_fired),
`endif
        .rst_out_n(o_out), .busy(o_busy), .seq_done(o_done));

    rst_seq_ctrl #(.N_CH(8), .HOLD(16), .STAGGER(3)) u_wide (
        .clk(clk), .rst_n(rst_n), .soft_rst_req(1'b0), .ch_mask(8'h00),
`ifdef RST_SEQ_WDT_EN
        .wdt_kick(1'b1), .wdt_fired(w_wdt_fired),
`endif
        .rst_out_n(w_out), .busy(w_busy), .seq_done(w_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rank_of(input logic [15:0] sel, input int k);
        int r = 0;
        for (int i = 0; i < k; i++) if (sel[i]) r++;
        return r;
    endfunction

    // Channel k in sel goes high after edge s+1+hold+rank*stag.
    function automatic logic [15:0] exp_out(input int n, input int hold, input int stag,
                                            input logic [15:0] sel, input int s, input int e);
        logic [15:0] r = '0;
        for (int k = 0; k < n; k++)
            r[k] = !sel[k] || (e >= s + 1 + hold + rank_of(sel, k) * stag);
        return r;
    endfunction

    // Edge after which seq_done is high.
    function automatic int done_at(input int n, input int hold, input int stag,
                                   input logic [15:0] sel, input int s);
        int p = 0;
        for (int k = 0; k < n; k++) if (sel[k]) p++;
        return s + 1 + hold + (p - 1) * stag + 1;
    endfunction

    // One clock: model updates on the rising edge, DUTs checked on the falling edge.
    task automatic step();
        int   d_main;
        int   start;
        logic in_run;
        logic [15:0] eo;
        @(posedge clk);
        ed++;
        m_fire = 1'b0;
        if (!rst_n) begin
            m_s   = ed;
            m_sel = 16'h000F;
            r_s   = ed;
        end else begin
            d_main = done_at(4, 16, 8, m_sel, m_s);
            in_run = (ed - 1) >= d_main;
`ifdef RST_SEQ_WDT_EN
            if (in_run) begin
                start = d_main + 1;
                if (last_kick + 1 > start) start = last_kick + 1;
                if (!wdt_kick && (ed - start) == TB_WDT - 1) m_fire = 1'b1;
                if (wdt_kick) last_kick = ed;
            end
`else
            start = 0;
`endif
            if (in_run && soft_rst_req && (ch_mask != 4'h0)) begin
                m_s   = ed;
                m_sel = {12'h000, ch_mask};
            end else if (m_fire) begin
                m_s   = ed;
                m_sel = 16'h000F;
            end
        end
        @(negedge clk);
        eo = exp_out(4, 16, 8, m_sel, m_s, ed);
        chk("main_out", 32'(m_out), 32'(eo[3:0]));
        chk("main_done", 32'(m_done), 32'(ed >= done_at(4, 16, 8, m_sel, m_s)));
        chk("main_busy", 32'(m_busy), 32'(ed < done_at(4, 16, 8, m_sel, m_s)));
        eo = exp_out(1, 1, 1, 16'h0001, r_s, ed);
        chk("one_out", 32'(o_out), 32'(eo[0]));
        chk("one_done", 32'(o_done), 32'(ed >= done_at(1, 1, 1, 16'h0001, r_s)));
        eo = exp_out(8, 16, 3, 16'h00FF, r_s, ed);
        chk("wide_out", 32'(w_out), 32'(eo[7:0]));
        chk("wide_busy", 32'(w_busy), 32'(ed < done_at(8, 16, 3, 16'h00FF, r_s)));
`ifdef RST_SEQ_WDT_EN
        chk("wdt_fired", 32'(m_wdt_fired), 32'(m_fire));
        chk("one_wdt", 32'(o_wdt_fired), 32'd0);
`endif
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    // Cold sequence from edge 0; optional ignored request and mid-run abort.
    task automatic cold_seq(input int req_edge, input int abort_edge);
        for (int e = 0; e <= 44; e++) begin
            soft_rst_req = (e == req_edge);
            ch_mask      = 4'hF;
            rst_n        = (e != abort_edge);
            step();
            soft_rst_req = 1'b0;
            if (e == abort_edge) begin
                chk("abort_out", 32'(m_out), 32'h0);
                chk("abort_busy", 32'(m_busy), 32'h1);
                rst_n = 1'b1;
                return;
            end
            if (e == 15) chk("cold_e15", 32'(m_out), 32'h0);
            if (e == 16) chk("cold_e16", 32'(m_out), 32'h1);
            if (e == 24) chk("cold_e24", 32'(m_out), 32'h3);
            if (e == 32) chk("cold_e32", 32'(m_out), 32'h7);
            if (e == 39) chk("cold_e39", 32'(m_out), 32'h7);
            if (e == 40) chk("cold_e40", 32'(m_out), 32'hF);
            if (e == 40) chk("cold_done40", 32'(m_done), 32'h0);
            if (e == 41) chk("cold_done41", 32'(m_done), 32'h1);
            if (e == 41) chk("cold_busy41", 32'(m_busy), 32'h0);
            if (e == 0)  chk("one_e0", 32'(o_out), 32'h0);
            if (e == 1)  chk("one_e1", 32'(o_out), 32'h1);
            if (e == 1)  chk("one_done1", 32'(o_done), 32'h0);
            if (e == 2)  chk("one_done2", 32'(o_done), 32'h1);
            if (e == 36) chk("wide_e36", 32'(w_out), 32'h7F);
            if (e == 37) chk("wide_e37", 32'(w_out), 32'hFF);
        end
    endtask

    initial begin
        int fired_cnt;
        rst_n        = 1'b0;
        soft_rst_req = 1'b0;
        ch_mask      = 4'h0;
        wdt_kick     = 1'b0;

        // Cold reset from power-up.
        do_reset(3);
        chk("reset_busy", 32'(m_busy), 32'h1);
        chk("reset_done", 32'(m_done), 32'h0);
        cold_seq(-1, -1);

        // Masked soft reset of channels 1 and 3.
        soft_rst_req = 1'b1;
        ch_mask      = 4'b1010;
        step();
        soft_rst_req = 1'b0;
        chk("soft_t", 32'(m_out), 32'h5);
        for (int e = 1; e <= 28; e++) begin
            step();
            if (e == 16) chk("soft_t16", 32'(m_out), 32'h5);
            if (e == 17) chk("soft_t17", 32'(m_out), 32'h7);
            if (e == 24) chk("soft_t24", 32'(m_out), 32'h7);
            if (e == 25) chk("soft_t25", 32'(m_out), 32'hF);
            if (e == 25) chk("soft_done25", 32'(m_done), 32'h0);
            if (e == 26) chk("soft_done26", 32'(m_done), 32'h1);
        end

        // Empty-mask request in RUN is ignored.
        soft_rst_req = 1'b1;
        ch_mask      = 4'h0;
        step();
        soft_rst_req = 1'b0;
        chk("mask0_out", 32'(m_out), 32'hF);
        chk("mask0_done", 32'(m_done), 32'h1);
        repeat (3) step();

        // Request during a cold sequence is ignored.
        do_reset(1);
        cold_seq(20, -1);

        // rst_n mid-sequence restarts everything.
        do_reset(2);
        cold_seq(-1, 28);
        cold_seq(-1, -1);

`ifdef RST_SEQ_WDT_EN
        // Unserviced watchdog forces a full re-sequence.
        wdt_kick  = 1'b0;
        fired_cnt = 0;
        for (int i = 0; i < 80 && fired_cnt == 0; i++) begin
            step();
            if (m_wdt_fired) fired_cnt++;
        end
        chk("wdt_fire_seen", 32'(fired_cnt), 32'd1);
        chk("wdt_fire_out", 32'(m_out), 32'h0);
        repeat (45) step();
        chk("wdt_reseq_out", 32'(m_out), 32'hF);
        // Regular servicing keeps it quiet.
        fired_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            wdt_kick = (i % 50 == 0);
            step();
            if (m_wdt_fired) fired_cnt++;
        end
        wdt_kick = 1'b0;
        chk("wdt_kicked_quiet", 32'(fired_cnt), 32'd0);
`else
        fired_cnt = 0;
`endif

        // Randomized soft resets, masks and occasional system resets.
        for (int i = 0; i < 800; i++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            soft_rst_req = ($urandom_range(0, 9) == 0);
            ch_mask      = 4'($urandom);
            wdt_kick     = ($urandom_range(0, 3) == 0);
            step();
        end
        rst_n        = 1'b1;
        soft_rst_req = 1'b0;
        wdt_kick     = 1'b0;
        repeat (50) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
